// File: rtl/mux8_rr_scheduler.sv
// ============================================================================
//  Module   : mux8_rr_scheduler (with helper mux8_1)
//  Function : Round-robin, time-sliced scheduler that shares one 8:1 bit mux
//             among eight requesters. One-hot grant, binary select and
//             gnt_valid are registered. data_out is combinational from data_in.
//  Options  : MUX8_SCHED_LOCK_EN - when defined, an owner asserting lock is
//             not pre-empted and its hold counter is frozen. When undefined,
//             the lock port is present but ignored.
//  Params   : MAX_HOLD (1..255) grant slice length in cycles,
//             CNT_W >= clog2(MAX_HOLD+1) hold counter width.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
//  mux8_1 : plain 8:1 single-bit select, purely combinational
// ----------------------------------------------------------------------------
module mux8_1 (
    input  logic [7:0] d,
    input  logic [2:0] sel,
    output logic       y
);

    // Bit select of the addressed input
    always_comb begin
        y = d[sel];
    end

endmodule

// ----------------------------------------------------------------------------
//  mux8_rr_scheduler : arbiter FSM around the shared mux8_1
// ----------------------------------------------------------------------------
module mux8_rr_scheduler #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] data_in,
    input  logic       lock,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       gnt_valid,
    output logic       data_out
);

    // Last legal hold count of a slice; reaching it is the pre-emption point
    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [7:0]       r_gnt;
    logic [2:0]       r_sel;
    logic             r_gnt_valid;

    logic [7:0]       w_owner_1h;
    logic [7:0]       w_cand;
    logic [2:0]       w_base;
    logic [2:0]       w_next_idx;
    logic             w_next_found;
    logic             w_owner_req;
    logic             w_others;
    logic             w_slice_end;
    logic             w_lock_hold;
    logic             w_mux_y;

`ifdef MUX8_SCHED_LOCK_EN
    // Owner lock freezes the slice; release still takes priority in the FSM
    assign w_lock_hold = lock;
`else
    // Lock feature compiled out: the port is accepted and discarded
    logic w_unused_lock;
    assign w_unused_lock = lock;
    assign w_lock_hold   = 1'b0;
`endif

    // Owner decode and the condition terms used by the GRANT state
    always_comb begin
        w_owner_1h  = 8'd1 << r_sel;
        w_owner_req = |(req & w_owner_1h);
        w_others    = |(req & ~w_owner_1h);
        w_slice_end = (r_hold_cnt == C_HOLD_LAST);
    end

    // Candidate set and search start: from ptr when idle, otherwise from the
    // index after the owner with the owner itself excluded. On a release the
    // owner's req is already low, so the same search serves both the release
    // and the slice-expiry handover.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_cand = req;
            w_base = r_ptr;
        end else begin
            w_cand = req & ~w_owner_1h;
            w_base = 3'(r_sel + 3'd1);
        end
    end

    // First set candidate in circular order base, base+1, ... base+7
    always_comb begin
        logic [2:0] idx;
        w_next_found = 1'b0;
        w_next_idx   = 3'd0;
        idx          = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(w_base + 3'(i));
            if (!w_next_found && w_cand[idx]) begin
                w_next_found = 1'b1;
                w_next_idx   = idx;
            end
        end
    end

    // Scheduler FSM with registered grant, select, valid and hold counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= 3'd0;
            r_hold_cnt  <= '0;
            r_gnt       <= 8'd0;
            r_sel       <= 3'd0;
            r_gnt_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_hold_cnt <= '0;
                    if (w_next_found) begin
                        r_gnt       <= 8'd1 << w_next_idx;
                        r_sel       <= w_next_idx;
                        r_gnt_valid <= 1'b1;
                        r_state     <= S_GRANT;
                    end
                end

                S_GRANT: begin
                    if (!w_owner_req) begin
                        // Release: move priority past the owner and hand over
                        // back-to-back if anyone else is waiting
                        r_ptr      <= 3'(r_sel + 3'd1);
                        r_hold_cnt <= '0;
                        if (w_next_found) begin
                            r_gnt       <= 8'd1 << w_next_idx;
                            r_sel       <= w_next_idx;
                            r_gnt_valid <= 1'b1;
                        end else begin
                            // sel keeps its last value while idle
                            r_gnt       <= 8'd0;
                            r_gnt_valid <= 1'b0;
                            r_state     <= S_IDLE;
                        end
                    end else if (w_lock_hold) begin
                        // Locked owner: no pre-emption, counter frozen
                        r_hold_cnt <= r_hold_cnt;
                    end else if (w_slice_end && w_others) begin
                        // Slice expired with waiters: pre-empt the owner
                        r_ptr       <= 3'(r_sel + 3'd1);
                        r_hold_cnt  <= '0;
                        r_gnt       <= 8'd1 << w_next_idx;
                        r_sel       <= w_next_idx;
                        r_gnt_valid <= 1'b1;
                    end else if (w_slice_end) begin
                        // Nobody waiting: keep the grant, counter saturated
                        r_hold_cnt <= r_hold_cnt;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_gnt       <= 8'd0;
                    r_gnt_valid <= 1'b0;
                    r_hold_cnt  <= '0;
                end
            endcase
        end
    end

    // Shared data channel: the mux is steered by the registered select
    mux8_1 u_mux (
        .d   (data_in),
        .sel (r_sel),
        .y   (w_mux_y)
    );

    // Output drive; data is forced low when nobody owns the channel
    always_comb begin
        gnt       = r_gnt;
        sel       = r_sel;
        gnt_valid = r_gnt_valid;
        data_out  = r_gnt_valid & w_mux_y;
    end

endmodule

`default_nettype wire

// File: tb/tb_mux8_rr_scheduler.sv
// ============================================================================
//  Module   : tb_mux8_rr_scheduler
//  Function : Directed self-checking bench for mux8_rr_scheduler (MAX_HOLD=4).
//             Expected values are hand-derived for each scenario. The lock
//             scenario expects different behaviour when MUX8_SCHED_LOCK_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux8_rr_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] data_in;
    logic       lock;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       gnt_valid;
    logic       data_out;

    int checks;
    int failures;

    mux8_rr_scheduler #(
        .MAX_HOLD (4),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .lock      (lock),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two-cycle reset with all requests cleared afterwards
    task automatic apply_reset();
        rst  = 1'b1;
        req  = 8'h00;
        lock = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        req     = 8'hFF;
        data_in = 8'hFF;
        lock    = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (gnt !== 8'h00 || sel !== 3'd0 || gnt_valid !== 1'b0 || data_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_state cyc=%0d got gnt=%h sel=%0d v=%b dout=%b want gnt=00 sel=0 v=0 dout=0",
                         c, gnt, sel, gnt_valid, data_out);
            end
        end
        rst = 1'b0;
        req = 8'h00;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got gnt=%h v=%b want gnt=00 v=0", gnt, gnt_valid);
        end
    endtask

    task automatic test_single_request();
        int bad;
        apply_reset();
        data_in = 8'h00;
        req     = 8'h20;
        tick();
        checks++;
        if (gnt !== 8'h20 || sel !== 3'd5 || gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got gnt=%h sel=%0d v=%b want gnt=20 sel=5 v=1", gnt, sel, gnt_valid);
        end
        data_in = 8'h20;
        #1;
        checks++;
        if (data_out !== 1'b1) begin
            failures++;
            $display("FAIL single_data_hi got %b want 1", data_out);
        end
        data_in = 8'hDF;
        #1;
        checks++;
        if (data_out !== 1'b0) begin
            failures++;
            $display("FAIL single_data_lo got %b want 0", data_out);
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gnt !== 8'h20) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL single_hold got %0d cycles off-grant (last gnt=%h) want 0", bad, gnt);
        end
        // Release with nobody waiting: back to idle, sel keeps its value
        req     = 8'h00;
        data_in = 8'hFF;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd5 || data_out !== 1'b0) begin
            failures++;
            $display("FAIL single_release got gnt=%h v=%b sel=%0d dout=%b want gnt=00 v=0 sel=5 dout=0",
                     gnt, gnt_valid, sel, data_out);
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_gnt;
        apply_reset();
        req = 8'h81;
        // Cycles 1-4 owner 0, 5-8 owner 7, 9-12 owner 0, 13-16 owner 7
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_gnt = ((((c - 1) / 4) % 2) == 0) ? 8'h01 : 8'h80;
            checks++;
            if (gnt !== exp_gnt || gnt_valid !== 1'b1) begin
                failures++;
                $display("FAIL contention cyc=%0d got gnt=%h v=%b want gnt=%h v=1", c, gnt, gnt_valid, exp_gnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        req = 8'h80;
        tick();
        checks++;
        if (gnt !== 8'h80 || sel !== 3'd7) begin
            failures++;
            $display("FAIL b2b_owner7 got gnt=%h sel=%0d want gnt=80 sel=7", gnt, sel);
        end
        req = 8'h86;
        tick();
        checks++;
        if (gnt !== 8'h80) begin
            failures++;
            $display("FAIL b2b_waiters_wait got gnt=%h want 80", gnt);
        end
        req     = 8'h06;
        data_in = 8'h02;
        tick();
        checks++;
        if (gnt !== 8'h02 || sel !== 3'd1 || gnt_valid !== 1'b1 || data_out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_wrap got gnt=%h sel=%0d v=%b dout=%b want gnt=02 sel=1 v=1 dout=1",
                     gnt, sel, gnt_valid, data_out);
        end
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        req = 8'h08;
        tick();
        tick();
        tick();
        checks++;
        if (gnt !== 8'h08) begin
            failures++;
            $display("FAIL midrst_owner3 got gnt=%h want 08", gnt);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || sel !== 3'd0) begin
            failures++;
            $display("FAIL midrst_drop got gnt=%h v=%b sel=%0d want gnt=00 v=0 sel=0", gnt, gnt_valid, sel);
        end
        rst = 1'b0;
        req = 8'h09;
        tick();
        checks++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            failures++;
            $display("FAIL midrst_regrant got gnt=%h sel=%0d want gnt=01 sel=0", gnt, sel);
        end
    endtask

    task automatic test_lock();
        int bad;
        apply_reset();
        req = 8'h10;
        tick();
        checks++;
        if (gnt !== 8'h10) begin
            failures++;
            $display("FAIL lock_owner4 got gnt=%h want 10", gnt);
        end
        req  = 8'h13;
        lock = 1'b1;
`ifdef MUX8_SCHED_LOCK_EN
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gnt !== 8'h10) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL lock_hold got %0d cycles pre-empted (last gnt=%h) want 0", bad, gnt);
        end
        lock = 1'b0;
`endif
        // Slice runs 3 more edges, pre-emption at the 4th (search 5,6,7,0)
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (gnt !== 8'h10) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL lock_slice got %0d early handovers (last gnt=%h) want 0", bad, gnt);
        end
        tick();
        checks++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            failures++;
            $display("FAIL lock_preempt got gnt=%h sel=%0d want gnt=01 sel=0", gnt, sel);
        end
        lock = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 8'h00;
        data_in  = 8'h00;
        lock     = 1'b0;
        test_reset();
        test_single_request();
        test_contention();
        test_back_to_back();
        test_reset_mid_grant();
        test_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
